// File: rtl/score_hex_formatter_if.sv
// Bus between the score formatter and its environment.
// Handshake: update_in is a single-cycle request with no ready; a request
// that arrives while busy_out=1 is remembered (coalesced) and served after
// the current conversion, and done_out pulses for one cycle when data_out
// has taken new score values.
interface score_hex_formatter_if #(
  parameter int CODE_W = 6
);
  logic [7:0]        bcount_in;
  logic [7:0]        wcount_in;
  logic              update_in;
  logic              game_over_in;
  logic [CODE_W-1:0] data_out [7:0];
  logic              busy_out;
  logic              done_out;
  logic [1:0]        state_dbg;

  // Environment side: drives counts and control, observes the display codes
  modport master (
    output bcount_in, wcount_in, update_in, game_over_in,
    input  data_out, busy_out, done_out, state_dbg
  );

  // Formatter side
  modport slave (
    input  bcount_in, wcount_in, update_in, game_over_in,
    output data_out, busy_out, done_out, state_dbg
  );
endinterface

// File: rtl/score_hex_formatter.sv
// Score formatter: converts the black/white territory counts to blanked
// 3-digit decimal codes with a bit-serial double-dabble, and alternates the
// score with a loser message while the game is over.
module score_hex_formatter #(
  parameter int BLINK_CYCLES = 32_500_000,
  parameter int CODE_W       = 6
) (
  input logic                  clk_in,
  input logic                  rst_in,
  score_hex_formatter_if.slave bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, CONV_B = 2'd1, CONV_W = 2'd2, LOAD = 2'd3} state_t;

  localparam logic [CODE_W-1:0] BLANK = CODE_W'(10);
  localparam logic [CODE_W-1:0] ZERO  = CODE_W'(0);
  // Message "JOE SUX " packed with index 7 (leftmost) in the top slot
  localparam logic [8*CODE_W-1:0] MSG_FLAT = {CODE_W'(20), CODE_W'(25), CODE_W'(15), CODE_W'(10),
                                              CODE_W'(29), CODE_W'(31), CODE_W'(34), CODE_W'(10)};
  localparam int CNT_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLINK_CYCLES - 1);

  state_t            state_q, state_d;
  logic [7:0]        bin_b_q, bin_w_q;
  logic [11:0]       bcd_b_q, bcd_w_q;
  logic [2:0]        bit_q;
  logic              pending_q;
  logic              done_q;
  logic [CODE_W-1:0] score_q [7:0];
  logic [CNT_W-1:0]  blink_cnt_q;
  logic              phase_q;
  logic              start_conv;
  logic [3*CODE_W-1:0] fmt_b, fmt_w;

  // One double-dabble iteration: add 3 to any nibble >= 5, then shift the bit in
  function automatic logic [11:0] dabble_step(input logic [11:0] bcd, input logic bin_msb);
    logic [11:0] adj;
    adj = bcd;
    for (int i = 0; i < 3; i++) begin
      if (adj[i*4 +: 4] >= 4'd5) adj[i*4 +: 4] = adj[i*4 +: 4] + 4'd3;
    end
    return {adj[10:0], bin_msb};
  endfunction

  // Hundreds/tens/ones codes with leading-zero blanking; ones always shown
  function automatic logic [3*CODE_W-1:0] fmt3(input logic [11:0] bcd);
    logic [CODE_W-1:0] h, t, o;
    h = (bcd[11:8] == 4'd0) ? BLANK : CODE_W'(bcd[11:8]);
    t = (bcd[11:4] == 8'd0) ? BLANK : CODE_W'(bcd[7:4]);
    o = CODE_W'(bcd[3:0]);
    return {h, t, o};
  endfunction

  // A new conversion starts from IDLE on a request, or straight out of LOAD
  // when a request was remembered or arrives in LOAD itself
  assign start_conv = ((state_q == IDLE) && bus.update_in) ||
                      ((state_q == LOAD) && (pending_q || bus.update_in));

  assign fmt_b = fmt3(bcd_b_q);
  assign fmt_w = fmt3(bcd_w_q);

  // FSM state register
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next-state logic: 8 iterations per colour, then one LOAD cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.update_in) state_d = CONV_B;
      CONV_B:  if (bit_q == 3'd7) state_d = CONV_W;
      CONV_W:  if (bit_q == 3'd7) state_d = LOAD;
      LOAD:    state_d = start_conv ? CONV_B : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    bus.busy_out  = (state_q != IDLE);
    bus.done_out  = done_q;
    bus.state_dbg = state_q;
  end

  // Conversion datapath, pending flag and score registers
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      bin_b_q   <= '0;
      bin_w_q   <= '0;
      bcd_b_q   <= '0;
      bcd_w_q   <= '0;
      bit_q     <= '0;
      pending_q <= 1'b0;
      done_q    <= 1'b0;
      for (int i = 0; i < 8; i++) score_q[i] <= BLANK;
      score_q[5] <= ZERO;
      score_q[0] <= ZERO;
    end else begin
      done_q <= (state_q == LOAD);
      // Requests during a conversion coalesce; LOAD consumes them
      if (state_q == CONV_B || state_q == CONV_W)
        pending_q <= pending_q | bus.update_in;
      else
        pending_q <= 1'b0;
      case (state_q)
        CONV_B: begin
          bcd_b_q <= dabble_step(bcd_b_q, bin_b_q[7]);
          bin_b_q <= {bin_b_q[6:0], 1'b0};
          bit_q   <= bit_q + 3'd1;
        end
        CONV_W: begin
          bcd_w_q <= dabble_step(bcd_w_q, bin_w_q[7]);
          bin_w_q <= {bin_w_q[6:0], 1'b0};
          bit_q   <= bit_q + 3'd1;
        end
        LOAD: begin
          score_q[7] <= fmt_b[2*CODE_W +: CODE_W];
          score_q[6] <= fmt_b[CODE_W +: CODE_W];
          score_q[5] <= fmt_b[0 +: CODE_W];
          score_q[4] <= BLANK;
          score_q[3] <= BLANK;
          score_q[2] <= fmt_w[2*CODE_W +: CODE_W];
          score_q[1] <= fmt_w[CODE_W +: CODE_W];
          score_q[0] <= fmt_w[0 +: CODE_W];
        end
        default: ;
      endcase
      // Inputs are latched only when a conversion actually starts
      if (start_conv) begin
        bin_b_q <= bus.bcount_in;
        bin_w_q <= bus.wcount_in;
        bcd_b_q <= '0;
        bcd_w_q <= '0;
        bit_q   <= '0;
      end
    end
  end

  // Blink timer: runs only while the game is over, phase 0 shows the message
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
    end else if (!bus.game_over_in) begin
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
    end else if (blink_cnt_q == CNT_MAX) begin
      blink_cnt_q <= '0;
      phase_q     <= ~phase_q;
    end else begin
      blink_cnt_q <= blink_cnt_q + CNT_W'(1);
    end
  end

  // Display mux: message or held score, never a partial conversion
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      bus.data_out[i] = (bus.game_over_in && !phase_q) ? MSG_FLAT[i*CODE_W +: CODE_W] : score_q[i];
    end
  end

endmodule

// File: tb/tb_score_hex_formatter.sv
// Directed and random bench for score_hex_formatter.
module tb_score_hex_formatter;

  logic clk_in;
  logic rst_in;
  int   n_checks;
  int   n_errors;
  logic [47:0] exp_q[$];

  score_hex_formatter_if #(.CODE_W(6)) bus ();

  score_hex_formatter #(.BLINK_CYCLES(4), .CODE_W(6)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus)
  );

  // Clock and reset
  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  function automatic logic [47:0] codes8(input int c7, c6, c5, c4, c3, c2, c1, c0);
    return {6'(c7), 6'(c6), 6'(c5), 6'(c4), 6'(c3), 6'(c2), 6'(c1), 6'(c0)};
  endfunction

  function automatic logic [47:0] dut_codes();
    logic [47:0] r;
    for (int i = 0; i < 8; i++) r[i*6 +: 6] = bus.data_out[i];
    return r;
  endfunction

  // Reference: arithmetic decimal split with leading-zero blanking
  function automatic logic [47:0] ref_score(input int b, input int w);
    int bh, bt, bo, wh, wt, wo;
    bh = b / 100; bt = (b / 10) % 10; bo = b % 10;
    wh = w / 100; wt = (w / 10) % 10; wo = w % 10;
    return codes8((bh == 0) ? 10 : bh, (b < 10) ? 10 : bt, bo, 10, 10,
                  (wh == 0) ? 10 : wh, (w < 10) ? 10 : wt, wo);
  endfunction

  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Driver: one update pulse, then wait (bounded) for done_out
  task automatic run_conv(input int b, input int w, output int lat);
    @(negedge clk_in);
    bus.bcount_in = 8'(b);
    bus.wcount_in = 8'(w);
    bus.update_in = 1'b1;
    @(negedge clk_in);
    bus.update_in = 1'b0;
    lat = 0;
    do begin
      @(negedge clk_in);
      lat++;
    end while (!bus.done_out && lat < 40);
    check("latency", 48'(lat), 48'd17);
  endtask

  initial begin
    int lat, ndone, b, w;
    logic [47:0] last_score;
    n_checks = 0;
    n_errors = 0;
    rst_in = 1'b1;
    bus.bcount_in = '0;
    bus.wcount_in = '0;
    bus.update_in = 1'b0;
    bus.game_over_in = 1'b0;
    repeat (3) @(negedge clk_in);
    rst_in = 1'b0;

    // Reset state
    check("rst_data", dut_codes(), codes8(10, 10, 0, 10, 10, 10, 10, 0));
    check("rst_busy", 48'(bus.busy_out), 48'd0);
    check("rst_done", 48'(bus.done_out), 48'd0);
    check("rst_state", 48'(bus.state_dbg), 48'd0);

    // 0 / 255
    run_conv(0, 255, lat);
    check("b0_w255", dut_codes(), codes8(10, 10, 0, 10, 10, 2, 5, 5));
    @(negedge clk_in);
    check("done_pulse_len", 48'(bus.done_out), 48'd0);
    check("idle_busy", 48'(bus.busy_out), 48'd0);

    // Blanking patterns
    run_conv(7, 40, lat);
    check("b7_w40", dut_codes(), codes8(10, 10, 7, 10, 10, 10, 4, 0));
    run_conv(100, 9, lat);
    check("b100_w9", dut_codes(), codes8(1, 0, 0, 10, 10, 10, 10, 9));
    run_conv(255, 10, lat);
    check("b255_w10", dut_codes(), codes8(2, 5, 5, 10, 10, 10, 1, 0));

    // Asynchronous reset in the middle of CONV_W
    @(negedge clk_in);
    bus.bcount_in = 8'd99;
    bus.wcount_in = 8'd199;
    bus.update_in = 1'b1;
    @(negedge clk_in);
    bus.update_in = 1'b0;
    repeat (11) @(negedge clk_in);
    check("mid_conv_busy", 48'(bus.busy_out), 48'd1);
    #2 rst_in = 1'b1;
    #1;
    check("async_rst_busy", 48'(bus.busy_out), 48'd0);
    check("async_rst_data", dut_codes(), codes8(10, 10, 0, 10, 10, 10, 10, 0));
    @(negedge clk_in);
    rst_in = 1'b0;
    ndone = 0;
    repeat (25) begin
      @(negedge clk_in);
      if (bus.done_out) ndone++;
    end
    check("rst_no_done", 48'(ndone), 48'd0);
    check("rst_data_held", dut_codes(), codes8(10, 10, 0, 10, 10, 10, 10, 0));

    // Coalesced requests during CONV_B
    @(negedge clk_in);
    bus.bcount_in = 8'd50;
    bus.wcount_in = 8'd60;
    bus.update_in = 1'b1;
    @(negedge clk_in);
    bus.update_in = 1'b0;
    ndone = 0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk_in);
      if (bus.done_out) begin
        ndone++;
        if (ndone == 1) begin
          check("coal_first", dut_codes(), codes8(10, 5, 0, 10, 10, 10, 6, 0));
          check("coal_busy_load", 48'(bus.busy_out), 48'd1);
          check("coal_first_at", 48'(c), 48'd17);
        end else if (ndone == 2) begin
          check("coal_second", dut_codes(), codes8(10, 1, 2, 10, 10, 10, 3, 4));
          check("coal_second_at", 48'(c), 48'd34);
        end
      end
      if (c == 2) begin
        bus.bcount_in = 8'd12;
        bus.wcount_in = 8'd34;
      end
      bus.update_in = (c == 2 || c == 4 || c == 6);
    end
    check("coal_count", 48'(ndone), 48'd2);
    check("coal_idle", 48'(bus.busy_out), 48'd0);
    last_score = codes8(10, 1, 2, 10, 10, 10, 3, 4);

    // Game over alternation with 4-cycle phases
    @(negedge clk_in);
    bus.game_over_in = 1'b1;
    #1;
    check("go_immediate", dut_codes(), codes8(20, 25, 15, 10, 29, 31, 34, 10));
    for (int i = 1; i < 12; i++) begin
      @(negedge clk_in);
      if (((i / 4) % 2) == 0)
        check("go_msg", dut_codes(), codes8(20, 25, 15, 10, 29, 31, 34, 10));
      else
        check("go_score", dut_codes(), last_score);
    end
    bus.game_over_in = 1'b0;
    @(negedge clk_in);
    check("go_drop", dut_codes(), last_score);

    // Random conversions against the decimal reference
    for (int k = 0; k < 500; k++) begin
      b = (k == 0) ? 0 : (k == 1) ? 255 : $urandom_range(0, 255);
      w = (k == 0) ? 0 : (k == 1) ? 255 : $urandom_range(0, 255);
      exp_q.push_back(ref_score(b, w));
      run_conv(b, w, lat);
      if (exp_q.size() > 0) check("rand", dut_codes(), exp_q.pop_front());
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
